// File: rtl/qacc_dot_if.sv
// qacc_dot_if: product-term input stream and result output stream of qacc_dot.
// master = producer/consumer side (testbench or upstream), slave = the accumulator.
interface qacc_dot_if #(
    parameter int unsigned N = 32
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] prod;
    logic         prod_ovr;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] acc_out;
    logic         acc_ovr;

    modport master (
        output in_valid, prod, prod_ovr, out_ready,
        input  in_ready, out_valid, acc_out, acc_ovr
    );

    modport slave (
        input  in_valid, prod, prod_ovr, out_ready,
        output in_ready, out_valid, acc_out, acc_ovr
    );
endinterface

// File: rtl/qacc_dot.sv
// qacc_dot: Q-format dot-product accumulator. Sums len pre-aligned product terms,
// tracks sticky overflow and holds the result until the consumer takes it.
// Optional macro QACC_SAT_EN: saturate on signed overflow instead of wrapping.
module qacc_dot #(
    parameter int unsigned Q  = 18,
    parameter int unsigned N  = 32,
    parameter int unsigned LW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [LW-1:0] len,
    output logic          busy,
    qacc_dot_if.slave     bus
);

    // Terms arrive already Q-aligned, so Q only has to be a sane fraction width.
    if (Q >= N) begin : g_bad_q
        $error("qacc_dot: Q must be smaller than N");
    end

    typedef enum logic [1:0] {IDLE, ACC, HOLD} state_t;

    state_t        state;
    state_t        state_nxt;
    logic [N-1:0]  acc;
    logic [N-1:0]  acc_nxt;
    logic          ovr;
    logic          ovr_nxt;
    logic [LW-1:0] cnt;
    logic [LW-1:0] cnt_nxt;
    logic [N:0]    sum_wide;
    logic          sum_ovf;
    logic [N-1:0]  sum_res;
    logic          take;

    // One-bit-wider signed sum; overflow when the two top bits disagree.
    always_comb begin
        sum_wide = {acc[N-1], acc} + {bus.prod[N-1], bus.prod};
        sum_ovf  = sum_wide[N] ^ sum_wide[N-1];
`ifdef QACC_SAT_EN
        if (sum_ovf) begin
            sum_res = sum_wide[N] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
        end else begin
            sum_res = sum_wide[N-1:0];
        end
`else
        sum_res = sum_wide[N-1:0];
`endif
    end

    assign take = bus.in_valid & bus.in_ready;

    // Next-state and next-datapath decode.
    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        ovr_nxt   = ovr;
        cnt_nxt   = cnt;
        unique case (state)
            IDLE: begin
                if (start) begin
                    acc_nxt = '0;
                    ovr_nxt = 1'b0;
                    if (len != '0) begin
                        cnt_nxt   = len;
                        state_nxt = ACC;
                    end else begin
                        cnt_nxt   = '0;
                        state_nxt = HOLD;
                    end
                end
            end
            ACC: begin
                if (take) begin
                    acc_nxt = sum_res;
                    ovr_nxt = ovr | bus.prod_ovr | sum_ovf;
                    cnt_nxt = cnt - LW'(1);
                    if (cnt == LW'(1)) begin
                        state_nxt = HOLD;
                    end
                end
            end
            HOLD: begin
                if (bus.out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Datapath registers and registered status outputs decoded from next state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc           <= '0;
            ovr           <= 1'b0;
            cnt           <= '0;
            bus.in_ready  <= 1'b0;
            bus.out_valid <= 1'b0;
            busy          <= 1'b0;
        end else begin
            acc           <= acc_nxt;
            ovr           <= ovr_nxt;
            cnt           <= cnt_nxt;
            bus.in_ready  <= (state_nxt == ACC);
            bus.out_valid <= (state_nxt == HOLD);
            busy          <= (state_nxt != IDLE);
        end
    end

    assign bus.acc_out = acc;
    assign bus.acc_ovr = ovr;

endmodule

// File: tb/tb_qacc_dot.sv
// tb_qacc_dot: scoreboard bench for qacc_dot (Q=18, N=32, LW=8).
module tb_qacc_dot;
    localparam int unsigned Q  = 18;
    localparam int unsigned N  = 32;
    localparam int unsigned LW = 8;

    typedef struct packed {
        logic [N-1:0] acc;
        logic         ovr;
    } res_t;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [LW-1:0] len   = '0;
    logic          busy;

    int errors = 0;
    int checks = 0;

    res_t         exp_q[$];
    logic [N-1:0] term_q[$];
    logic         tovr_q[$];

    qacc_dot_if #(.N(N)) bus ();

    qacc_dot #(.Q(Q), .N(N), .LW(LW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .len   (len),
        .busy  (busy),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // Reference accumulate step using 64-bit arithmetic and explicit range limits.
    function automatic res_t model_step(input res_t r, input logic [N-1:0] p, input logic po);
        longint s;
        longint maxv;
        longint minv;
        maxv = (longint'(1) <<< (N-1)) - 1;
        minv = -(longint'(1) <<< (N-1));
        s = longint'($signed(r.acc)) + longint'($signed(p));
        if (s > maxv || s < minv) begin
            r.ovr = 1'b1;
`ifdef QACC_SAT_EN
            r.acc = (s > maxv) ? maxv[N-1:0] : minv[N-1:0];
`else
            r.acc = s[N-1:0];
`endif
        end else begin
            r.acc = s[N-1:0];
        end
        r.ovr = r.ovr | po;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full transaction using term_q/tovr_q; gap idle cycles between terms,
    // hold cycles of out_ready=0 in HOLD, optional start pulses while busy.
    task automatic run_txn(input int l, input int gap, input int hold, input bit pulse_start);
        res_t r;
        res_t e;
        int   w;
        r = '0;
        start = 1'b1;
        len   = LW'(l);
        tick();
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_after_start: got %b want 1", busy);
        end
        for (int i = 0; i < l; i++) begin
            r = model_step(r, term_q[i], tovr_q[i]);
            bus.in_valid = 1'b1;
            bus.prod     = term_q[i];
            bus.prod_ovr = tovr_q[i];
            if (pulse_start) begin
                start = 1'b1;
                len   = LW'(3);
            end
            checks++;
            if (bus.in_ready !== 1'b1) begin
                errors++;
                $display("FAIL in_ready_acc: term %0d got %b want 1", i, bus.in_ready);
            end
            tick();
            start        = 1'b0;
            bus.in_valid = 1'b0;
            bus.prod_ovr = 1'b1;
            bus.prod     = 32'h1234_5678;
            if (i < l - 1) begin
                for (int g = 0; g < gap; g++) begin
                    tick();
                end
            end
            bus.prod_ovr = 1'b0;
        end
        exp_q.push_back(r);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL latency: out_valid=%b in_ready=%b want 1/0", bus.out_valid, bus.in_ready);
        end
        for (int h = 0; h < hold; h++) begin
            if (pulse_start) start = 1'b1;
            tick();
            start = 1'b0;
            checks++;
            if (bus.out_valid !== 1'b1 || bus.acc_out !== exp_q[0].acc || bus.acc_ovr !== exp_q[0].ovr) begin
                errors++;
                $display("FAIL hold_stable: cyc %0d out_valid=%b acc=%h ovr=%b want 1 %h %b",
                         h, bus.out_valid, bus.acc_out, bus.acc_ovr, exp_q[0].acc, exp_q[0].ovr);
            end
        end
        w = 0;
        while (bus.out_valid !== 1'b1 && w < 50) begin
            tick();
            w++;
        end
        bus.out_ready = 1'b1;
        if (pulse_start) start = 1'b1;
        e = exp_q.pop_front();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.acc_out !== e.acc || bus.acc_ovr !== e.ovr) begin
            errors++;
            $display("FAIL result: out_valid=%b acc=%h ovr=%b want 1 %h %b",
                     bus.out_valid, bus.acc_out, bus.acc_ovr, e.acc, e.ovr);
        end
        tick();
        bus.out_ready = 1'b0;
        start         = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL release: out_valid=%b busy=%b want 0/0", bus.out_valid, busy);
        end
        term_q.delete();
        tovr_q.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        checks++;
        if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 || busy !== 1'b0 ||
            bus.acc_out !== '0 || bus.acc_ovr !== 1'b0) begin
            errors++;
            $display("FAIL reset_values: in_ready=%b out_valid=%b busy=%b acc=%h ovr=%b want all 0",
                     bus.in_ready, bus.out_valid, busy, bus.acc_out, bus.acc_ovr);
        end
        start = 1'b1;
        len   = '0;
        rst_n = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b1 || bus.acc_out !== '0) begin
            errors++;
            $display("FAIL first_start: out_valid=%b acc=%h want 1 0", bus.out_valid, bus.acc_out);
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL first_release: busy=%b want 0", busy);
        end
    endtask

    task automatic test_basic();
        term_q = '{32'h0004_0000, 32'h0002_0000, 32'hFFFE_0000};
        tovr_q = '{1'b0, 1'b0, 1'b0};
        run_txn(3, 0, 0, 1'b0);
    endtask

    task automatic test_len_zero();
        bus.in_valid = 1'b1;
        bus.prod     = 32'h0100_0000;
        start = 1'b1;
        len   = '0;
        tick();
        start = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b1 || bus.acc_out !== '0 || bus.acc_ovr !== 1'b0 || bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL len_zero: out_valid=%b acc=%h ovr=%b in_ready=%b want 1 0 0 0",
                     bus.out_valid, bus.acc_out, bus.acc_ovr, bus.in_ready);
        end
        tick();
        checks++;
        if (bus.acc_out !== '0 || bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL len_zero_consume: acc=%h in_ready=%b want 0 0", bus.acc_out, bus.in_ready);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL len_zero_release: busy=%b want 0", busy);
        end
    endtask

    task automatic test_overflow();
        term_q = '{32'h7FFF_0000, 32'h7FFF_0000};
        tovr_q = '{1'b0, 1'b0};
        run_txn(2, 0, 1, 1'b0);
    endtask

    task automatic test_stall();
        term_q = '{32'h0001_0000, 32'hFFFF_8000, 32'h0003_0000, 32'h0000_2000};
        tovr_q = '{1'b0, 1'b1, 1'b0, 1'b0};
        run_txn(4, 1, 5, 1'b0);
    endtask

    task automatic test_reset_mid();
        start = 1'b1;
        len   = LW'(4);
        tick();
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus.in_valid = 1'b1;
            bus.prod     = 32'h0005_0000;
            bus.prod_ovr = 1'b1;
            tick();
        end
        bus.in_valid = 1'b0;
        bus.prod_ovr = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++;
        if (busy !== 1'b0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0 ||
            bus.acc_out !== '0 || bus.acc_ovr !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: busy=%b out_valid=%b in_ready=%b acc=%h ovr=%b want all 0",
                     busy, bus.out_valid, bus.in_ready, bus.acc_out, bus.acc_ovr);
        end
        term_q = '{32'h0001_0000};
        tovr_q = '{1'b0};
        run_txn(1, 0, 0, 1'b0);
    endtask

    task automatic test_start_ignored();
        term_q = '{32'h0000_8000, 32'h0001_4000, 32'hFFFF_F000};
        tovr_q = '{1'b0, 1'b0, 1'b0};
        run_txn(3, 0, 2, 1'b1);
    endtask

    task automatic test_back_to_back();
        int l;
        for (int t = 0; t < 6; t++) begin
            l = int'($urandom_range(1, 6));
            for (int i = 0; i < l; i++) begin
                term_q.push_back($urandom());
                tovr_q.push_back(($urandom_range(0, 7) == 0) ? 1'b1 : 1'b0);
            end
            run_txn(l, int'($urandom_range(0, 1)), int'($urandom_range(0, 2)), 1'b0);
        end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.prod      = '0;
        bus.prod_ovr  = 1'b0;
        bus.out_ready = 1'b0;
        test_reset();
        test_basic();
        test_len_zero();
        test_overflow();
        test_stall();
        test_reset_mid();
        test_start_ignored();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Absolute watchdog so the run can never hang.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout want finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/qacc_dot.md
QACC_DOT -- requirements
Module: qacc_dot

Interface
REQ-001 Parameter Q, default 18: fraction bits of every fixed-point word.
REQ-002 Parameter N, default 32: total word width, two's complement signed.
REQ-003 Parameter LW, default 8: width of the term-count input.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 start  input  1  begin a new dot product; sampled only in IDLE.
REQ-007 len  input  LW  number of product terms; sampled with start.
REQ-008 in_valid  input  1  prod/prod_ovr carry a valid product term.
REQ-009 in_ready  output  1  block accepts a term this cycle.
REQ-010 prod  input  N  signed Q-format product from the upstream multiplier.
REQ-011 prod_ovr  input  1  overflow flag accompanying prod.
REQ-012 out_valid  output  1  acc_out/acc_ovr hold a finished result.
REQ-013 out_ready  input  1  consumer takes the result.
REQ-014 acc_out  output  N  signed Q-format accumulated sum.
REQ-015 acc_ovr  output  1  sticky overflow for the current result.
REQ-016 busy  output  1  high in any state other than IDLE.

Function
REQ-017 FSM states are IDLE, ACC and HOLD.
REQ-018 IDLE with start=1 and len!=0: clear the accumulator and acc_ovr, load the counter with len, go to ACC.
REQ-019 IDLE with start=1 and len==0: set acc_out=0 and acc_ovr=0, go directly to HOLD.
REQ-020 start is ignored in ACC and HOLD; no queuing.
REQ-021 in_ready is 1 only in ACC; a term is accepted when in_valid and in_ready are both 1 on a rising edge.
REQ-022 Each accepted term: acc <= acc + prod, computed N+1 bits wide; acc_ovr <= acc_ovr | prod_ovr | signed overflow of the N-bit sum.
REQ-023 Each accepted term decrements the counter.
REQ-024 When the term that takes the counter from 1 to 0 is accepted, go to HOLD; out_valid is asserted on the next cycle (latency is 1 clk after the last term).
REQ-025 No Q-shift is applied: terms are already Q-aligned, so acc_out uses the same Q format.
REQ-026 HOLD: out_valid=1, and acc_out/acc_ovr are stable until the handshake.
REQ-027 HOLD with out_ready=1: go to IDLE; out_valid falls on the next cycle.
REQ-028 If start and the out_ready handshake coincide in HOLD, start is ignored.
REQ-029 in_valid while in_ready=0 is ignored; the upstream holds the data.
REQ-030 prod_ovr on a non-accepted cycle has no effect.

Reset
REQ-031 On any clk edge with rst_n=0 the block returns to IDLE, including mid-ACC or mid-HOLD; any partial sum is discarded.
REQ-032 Reset values: in_ready=0, out_valid=0, busy=0, acc_out=0, acc_ovr=0, counter=0.
REQ-033 The first start is honoured on the first edge with rst_n=1.

Configuration
REQ-034 With macro QACC_SAT_EN defined, on signed overflow acc saturates to 2^(N-1)-1 (positive) or -2^(N-1) (negative), and acc_ovr=1.
REQ-035 Without QACC_SAT_EN, acc wraps modulo 2^N, and acc_ovr is still set per REQ-022.

Verification (Q=18, N=32)
REQ-036 Terms 0x00040000, 0x00020000, 0xFFFE0000 with len=3 -> acc_out=0x00040000 (1.0), acc_ovr=0, out_valid 1 clk after the 3rd term.
REQ-037 len=0 with start -> next cycle out_valid=1, acc_out=0, acc_ovr=0, no terms consumed.
REQ-038 len=2, terms 0x7FFF0000 and 0x7FFF0000 -> with QACC_SAT_EN acc_out=0x7FFFFFFF; without it acc_out=0xFFFE0000; acc_ovr=1 in both builds.
REQ-039 len=4, in_valid toggling every other cycle, one term with prod_ovr=1 -> result is correct, acc_ovr=1, and out_valid is held while out_ready=0 for 5 cycles.
REQ-040 rst_n=0 after 2 of 4 terms, then a new start with len=1 and term 0x00010000 -> acc_out=0x00010000, acc_ovr=0.
REQ-041 start pulsed during ACC and HOLD -> ignored; term count and result unaffected.
